// File: rtl/motor_ramp_ctrl_if.sv
// Command channel of motor_ramp_ctrl: one move command handed over per valid/ready handshake.
interface motor_ramp_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [WIDTH-1:0] cmd_steps;
  logic [WIDTH-1:0] cmd_start_period;
  logic [WIDTH-1:0] cmd_min_period;
  logic [WIDTH-1:0] cmd_ramp_step;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_start_period, cmd_min_period, cmd_ramp_step,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_start_period, cmd_min_period, cmd_ramp_step,
    output cmd_ready
  );
endinterface

// File: rtl/motor_ramp_ctrl.sv
// Trapezoid/triangle step-delay sequencer feeding the motor pulse stage.
// Ramping (ACCEL/DECEL) is built only when MOTOR_RAMP_EN is defined; otherwise moves run at cmd_min_period.
module motor_ramp_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             Motor_Clk,
  input  logic             Motor_Rst,
  motor_ramp_ctrl_if.slave cmd,
  input  logic             step_pulse,
  input  logic             abort,
  output logic             direction,
  output logic [WIDTH-1:0] pwm,
  output logic [WIDTH-1:0] pulse_num,
  output logic [WIDTH-1:0] steps_done,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [2:0] {
    IDLE,
    ACCEL,
    CRUISE,
    DECEL,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] min_r;
  logic [WIDTH-1:0] rem_dec;

  assign rem_dec = pulse_num - ONE;

`ifdef MOTOR_RAMP_EN
  logic [WIDTH-1:0] start_r;
  logic [WIDTH-1:0] ramp_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] start_sel;
  logic [WIDTH:0]   min_plus_ramp;
  logic [WIDTH:0]   p_add_full;
  logic [WIDTH-1:0] p_sub;
  logic [WIDTH-1:0] p_add;

  assign start_sel = (cmd.cmd_start_period > cmd.cmd_min_period) ?
                     cmd.cmd_start_period : cmd.cmd_min_period;

  // Both ramp directions are evaluated one bit wide so they saturate instead of wrapping.
  assign min_plus_ramp = {1'b0, min_r} + {1'b0, ramp_r};
  assign p_sub         = ({1'b0, pwm} < min_plus_ramp) ? min_r : (pwm - ramp_r);
  assign p_add_full    = {1'b0, pwm} + {1'b0, ramp_r};
  assign p_add         = (p_add_full > {1'b0, start_r}) ? start_r : p_add_full[WIDTH-1:0];
`endif

  // pwm doubles as the current step delay; it is forced to 0 whenever no move is running.
  always_ff @(posedge Motor_Clk or posedge Motor_Rst) begin
    if (Motor_Rst) begin
      state         <= IDLE;
      cmd.cmd_ready <= 1'b1;
      direction     <= 1'b0;
      pwm           <= '0;
      pulse_num     <= '0;
      steps_done    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      min_r         <= '0;
`ifdef MOTOR_RAMP_EN
      start_r       <= '0;
      ramp_r        <= '0;
      acc           <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (cmd.cmd_valid) begin
            cmd.cmd_ready <= 1'b0;
            direction     <= cmd.cmd_dir;
            min_r         <= cmd.cmd_min_period;
            pulse_num     <= cmd.cmd_steps;
            steps_done    <= '0;
            aborted       <= 1'b0;
`ifdef MOTOR_RAMP_EN
            start_r       <= start_sel;
            ramp_r        <= cmd.cmd_ramp_step;
            acc           <= '0;
`endif
            if (cmd.cmd_steps == '0) begin
              state <= DONE;
              done  <= 1'b1;
              pwm   <= '0;
            end else begin
              busy <= 1'b1;
`ifdef MOTOR_RAMP_EN
              pwm <= start_sel;
              if ((start_sel == cmd.cmd_min_period) || (cmd.cmd_ramp_step == '0)) begin
                state <= CRUISE;
              end else begin
                state <= ACCEL;
              end
`else
              pwm   <= cmd.cmd_min_period;
              state <= CRUISE;
`endif
            end
          end
        end

        ACCEL, CRUISE, DECEL: begin
          if (step_pulse) begin
            pulse_num  <= rem_dec;
            steps_done <= steps_done + ONE;
          end
          if (abort || (step_pulse && (rem_dec == '0))) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            pwm   <= '0;
            if (abort) begin
              aborted <= 1'b1;
            end
          end
`ifdef MOTOR_RAMP_EN
          else if (step_pulse) begin
            // Deceleration starts once the remaining steps no longer cover the steps spent accelerating.
            case (state)
              ACCEL: begin
                if (rem_dec <= acc) begin
                  state <= DECEL;
                end else begin
                  pwm <= p_sub;
                  acc <= acc + ONE;
                  if (p_sub == min_r) begin
                    state <= CRUISE;
                  end
                end
              end
              CRUISE: begin
                if (rem_dec <= acc) begin
                  state <= DECEL;
                end
              end
              DECEL: begin
                pwm <= p_add;
              end
              default: begin
              end
            endcase
          end
`endif
        end

        DONE: begin
          done          <= 1'b0;
          cmd.cmd_ready <= 1'b1;
          state         <= IDLE;
        end

        default: begin
          state         <= IDLE;
          cmd.cmd_ready <= 1'b1;
          busy          <= 1'b0;
          done          <= 1'b0;
          pwm           <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl; expected profiles follow MOTOR_RAMP_EN.
module tb_motor_ramp_ctrl;

  localparam int WIDTH = 32;

  logic             motor_clk;
  logic             motor_rst;
  logic             step_pulse;
  logic             abort;
  logic             direction;
  logic [WIDTH-1:0] pwm;
  logic [WIDTH-1:0] pulse_num;
  logic [WIDTH-1:0] steps_done;
  logic             busy;
  logic             done;
  logic             aborted;

  int vectors;
  int miscompares;

  motor_ramp_ctrl_if #(.WIDTH(WIDTH)) cif ();

  motor_ramp_ctrl #(.WIDTH(WIDTH)) dut (
    .Motor_Clk  (motor_clk),
    .Motor_Rst  (motor_rst),
    .cmd        (cif.slave),
    .step_pulse (step_pulse),
    .abort      (abort),
    .direction  (direction),
    .pwm        (pwm),
    .pulse_num  (pulse_num),
    .steps_done (steps_done),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  initial motor_clk = 1'b0;
  always #5 motor_clk = ~motor_clk;

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_cmd(input logic dir, input logic [31:0] steps, input logic [31:0] start,
                          input logic [31:0] min_p, input logic [31:0] ramp);
    cif.cmd_valid        = 1'b1;
    cif.cmd_dir          = dir;
    cif.cmd_steps        = steps;
    cif.cmd_start_period = start;
    cif.cmd_min_period   = min_p;
    cif.cmd_ramp_step    = ramp;
    @(posedge motor_clk);
    #1;
    cif.cmd_valid = 1'b0;
  endtask

  task automatic do_step();
    step_pulse = 1'b1;
    @(posedge motor_clk);
    #1;
    step_pulse = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge motor_clk);
    #1;
  endtask

  task automatic test_reset();
    motor_rst = 1'b1;
    #2;
    vectors++;
    if (cif.cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 || direction !== 1'b0) begin
      $display("[TB] FAIL reset_flags: got ready=%b busy=%b done=%b aborted=%b dir=%b expected 1 0 0 0 0",
               cif.cmd_ready, busy, done, aborted, direction);
      miscompares++;
    end
    vectors++;
    if (pwm !== 32'd0 || pulse_num !== 32'd0 || steps_done !== 32'd0) begin
      $display("[TB] FAIL reset_values: got pwm=%0d pulse_num=%0d steps_done=%0d expected 0 0 0",
               pwm, pulse_num, steps_done);
      miscompares++;
    end
    @(negedge motor_clk);
    @(negedge motor_clk);
    motor_rst = 1'b0;
    @(posedge motor_clk);
    #1;
  endtask

  task automatic test_trapezoid();
`ifdef MOTOR_RAMP_EN
    int exp_pwm[8] = '{10, 8, 6, 4, 4, 4, 6, 8};
`else
    int exp_pwm[8] = '{4, 4, 4, 4, 4, 4, 4, 4};
`endif
    send_cmd(1'b1, 32'd8, 32'd10, 32'd4, 32'd2);
    vectors++;
    if (busy !== 1'b1 || cif.cmd_ready !== 1'b0 || direction !== 1'b1 || pulse_num !== 32'd8) begin
      $display("[TB] FAIL trap_accept: got busy=%b ready=%b dir=%b pulse_num=%0d expected 1 0 1 8",
               busy, cif.cmd_ready, direction, pulse_num);
      miscompares++;
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (pwm !== 32'(exp_pwm[i]) || pulse_num !== 32'(8 - i)) begin
        $display("[TB] FAIL trap_step%0d: got pwm=%0d rem=%0d expected %0d %0d",
                 i + 1, pwm, pulse_num, exp_pwm[i], 8 - i);
        miscompares++;
      end
      do_step();
    end
    vectors++;
    if (pwm !== 32'd0 || done !== 1'b1 || busy !== 1'b0 || steps_done !== 32'd8 || pulse_num !== 32'd0) begin
      $display("[TB] FAIL trap_end: got pwm=%0d done=%b busy=%b steps_done=%0d rem=%0d expected 0 1 0 8 0",
               pwm, done, busy, steps_done, pulse_num);
      miscompares++;
    end
    idle_cycle();
    vectors++;
    if (done !== 1'b0 || cif.cmd_ready !== 1'b1) begin
      $display("[TB] FAIL trap_ready: got done=%b ready=%b expected 0 1", done, cif.cmd_ready);
      miscompares++;
    end
  endtask

  task automatic test_triangle();
`ifdef MOTOR_RAMP_EN
    int exp_pwm[4] = '{10, 8, 6, 6};
`else
    int exp_pwm[4] = '{2, 2, 2, 2};
`endif
    send_cmd(1'b0, 32'd4, 32'd10, 32'd2, 32'd2);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (pwm !== 32'(exp_pwm[i]) || busy !== 1'b1) begin
        $display("[TB] FAIL tri_step%0d: got pwm=%0d busy=%b expected %0d 1", i + 1, pwm, busy, exp_pwm[i]);
        miscompares++;
      end
      do_step();
    end
    vectors++;
    if (pwm !== 32'd0 || done !== 1'b1 || steps_done !== 32'd4 || direction !== 1'b0) begin
      $display("[TB] FAIL tri_end: got pwm=%0d done=%b steps_done=%0d dir=%b expected 0 1 4 0",
               pwm, done, steps_done, direction);
      miscompares++;
    end
    idle_cycle();
  endtask

  task automatic test_zero_steps();
    send_cmd(1'b1, 32'd0, 32'd10, 32'd4, 32'd2);
    vectors++;
    if (done !== 1'b1 || pwm !== 32'd0 || busy !== 1'b0 || cif.cmd_ready !== 1'b0) begin
      $display("[TB] FAIL zero_done: got done=%b pwm=%0d busy=%b ready=%b expected 1 0 0 0",
               done, pwm, busy, cif.cmd_ready);
      miscompares++;
    end
    idle_cycle();
    vectors++;
    if (done !== 1'b0 || pwm !== 32'd0 || cif.cmd_ready !== 1'b1 || steps_done !== 32'd0) begin
      $display("[TB] FAIL zero_ready: got done=%b pwm=%0d ready=%b steps_done=%0d expected 0 0 1 0",
               done, pwm, cif.cmd_ready, steps_done);
      miscompares++;
    end
  endtask

  task automatic test_abort();
    send_cmd(1'b1, 32'd10, 32'd10, 32'd4, 32'd2);
    do_step();
    // A new command offered mid-move must not disturb the latched one.
    cif.cmd_valid = 1'b1;
    cif.cmd_dir   = 1'b0;
    cif.cmd_steps = 32'd99;
    do_step();
    cif.cmd_valid = 1'b0;
    vectors++;
    if (pulse_num !== 32'd8 || direction !== 1'b1 || steps_done !== 32'd2) begin
      $display("[TB] FAIL busy_cmd_ignored: got rem=%0d dir=%b steps_done=%0d expected 8 1 2",
               pulse_num, direction, steps_done);
      miscompares++;
    end
    abort      = 1'b1;
    step_pulse = 1'b1;
    @(posedge motor_clk);
    #1;
    abort      = 1'b0;
    step_pulse = 1'b0;
    vectors++;
    if (steps_done !== 32'd3 || pulse_num !== 32'd7 || pwm !== 32'd0 || done !== 1'b1 || aborted !== 1'b1) begin
      $display("[TB] FAIL abort_step: got steps_done=%0d rem=%0d pwm=%0d done=%b aborted=%b expected 3 7 0 1 1",
               steps_done, pulse_num, pwm, done, aborted);
      miscompares++;
    end
    idle_cycle();
    abort      = 1'b1;
    step_pulse = 1'b1;
    idle_cycle();
    abort      = 1'b0;
    step_pulse = 1'b0;
    vectors++;
    if (steps_done !== 32'd3 || pulse_num !== 32'd7 || aborted !== 1'b1 || cif.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      $display("[TB] FAIL idle_ignore: got steps_done=%0d rem=%0d aborted=%b ready=%b busy=%b expected 3 7 1 1 0",
               steps_done, pulse_num, aborted, cif.cmd_ready, busy);
      miscompares++;
    end
  endtask

  task automatic test_boundary();
    logic [31:0] c_start[3] = '{32'd9, 32'd3, 32'd5};
    logic [31:0] c_min[3]   = '{32'd4, 32'd6, 32'd1};
    logic [31:0] c_ramp[3]  = '{32'd3, 32'd2, 32'hFFFF_FFF0};
    int          c_steps[3] = '{6, 2, 2};
`ifdef MOTOR_RAMP_EN
    int exp_pwm[3][6] = '{'{9, 6, 4, 4, 4, 7}, '{6, 6, 0, 0, 0, 0}, '{5, 1, 0, 0, 0, 0}};
`else
    int exp_pwm[3][6] = '{'{4, 4, 4, 4, 4, 4}, '{6, 6, 0, 0, 0, 0}, '{1, 1, 0, 0, 0, 0}};
`endif
    for (int c = 0; c < 3; c++) begin
      send_cmd(1'b1, 32'(c_steps[c]), c_start[c], c_min[c], c_ramp[c]);
      if (c == 0) begin
        vectors++;
        if (aborted !== 1'b0 || steps_done !== 32'd0) begin
          $display("[TB] FAIL accept_clears: got aborted=%b steps_done=%0d expected 0 0", aborted, steps_done);
          miscompares++;
        end
      end
      for (int i = 0; i < c_steps[c]; i++) begin
        vectors++;
        if (pwm !== 32'(exp_pwm[c][i])) begin
          $display("[TB] FAIL bound%0d_step%0d: got pwm=%0d expected %0d", c, i + 1, pwm, exp_pwm[c][i]);
          miscompares++;
        end
        do_step();
      end
      vectors++;
      if (done !== 1'b1 || pwm !== 32'd0 || steps_done !== 32'(c_steps[c])) begin
        $display("[TB] FAIL bound%0d_end: got done=%b pwm=%0d steps_done=%0d expected 1 0 %0d",
                 c, done, pwm, steps_done, c_steps[c]);
        miscompares++;
      end
      idle_cycle();
    end
  endtask

  task automatic test_back_to_back();
`ifdef MOTOR_RAMP_EN
    int exp_pwm[3] = '{10, 8, 8};
`else
    int exp_pwm[3] = '{4, 4, 4};
`endif
    for (int m = 0; m < 2; m++) begin
      if (m == 0) begin
        send_cmd(1'b0, 32'd3, 32'd10, 32'd4, 32'd2);
      end
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (pwm !== 32'(exp_pwm[i])) begin
          $display("[TB] FAIL b2b%0d_step%0d: got pwm=%0d expected %0d", m, i + 1, pwm, exp_pwm[i]);
          miscompares++;
        end
        do_step();
      end
      vectors++;
      if (done !== 1'b1 || steps_done !== 32'd3 || pwm !== 32'd0) begin
        $display("[TB] FAIL b2b%0d_done: got done=%b steps_done=%0d pwm=%0d expected 1 3 0",
                 m, done, steps_done, pwm);
        miscompares++;
      end
      if (m == 0) begin
        // Command held from edge K+1; it may only be taken at K+2.
        cif.cmd_valid = 1'b1;
        idle_cycle();
        vectors++;
        if (busy !== 1'b0 || cif.cmd_ready !== 1'b1 || done !== 1'b0) begin
          $display("[TB] FAIL b2b_k1: got busy=%b ready=%b done=%b expected 0 1 0", busy, cif.cmd_ready, done);
          miscompares++;
        end
        idle_cycle();
        cif.cmd_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1 || cif.cmd_ready !== 1'b0 || steps_done !== 32'd0 || pulse_num !== 32'd3) begin
          $display("[TB] FAIL b2b_k2: got busy=%b ready=%b steps_done=%0d rem=%0d expected 1 0 0 3",
                   busy, cif.cmd_ready, steps_done, pulse_num);
          miscompares++;
        end
      end else begin
        idle_cycle();
      end
    end
  endtask

  task automatic test_reset_midmove();
    send_cmd(1'b1, 32'd10, 32'd5, 32'd5, 32'd1);
    do_step();
    vectors++;
    if (busy !== 1'b1 || pwm !== 32'd5) begin
      $display("[TB] FAIL rst_pre: got busy=%b pwm=%0d expected 1 5", busy, pwm);
      miscompares++;
    end
    #2;
    motor_rst = 1'b1;
    #1;
    vectors++;
    if (pwm !== 32'd0 || busy !== 1'b0 || cif.cmd_ready !== 1'b1 || pulse_num !== 32'd0 || steps_done !== 32'd0) begin
      $display("[TB] FAIL rst_async: got pwm=%0d busy=%b ready=%b rem=%0d steps_done=%0d expected 0 0 1 0 0",
               pwm, busy, cif.cmd_ready, pulse_num, steps_done);
      miscompares++;
    end
    @(negedge motor_clk);
    motor_rst            = 1'b0;
    cif.cmd_valid        = 1'b1;
    cif.cmd_dir          = 1'b0;
    cif.cmd_steps        = 32'd2;
    cif.cmd_start_period = 32'd7;
    cif.cmd_min_period   = 32'd7;
    cif.cmd_ramp_step    = 32'd1;
    @(posedge motor_clk);
    #1;
    cif.cmd_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || pwm !== 32'd7 || cif.cmd_ready !== 1'b0 || pulse_num !== 32'd2) begin
      $display("[TB] FAIL rst_reaccept: got busy=%b pwm=%0d ready=%b rem=%0d expected 1 7 0 2",
               busy, pwm, cif.cmd_ready, pulse_num);
      miscompares++;
    end
    do_step();
    do_step();
    vectors++;
    if (done !== 1'b1 || steps_done !== 32'd2) begin
      $display("[TB] FAIL rst_move_end: got done=%b steps_done=%0d expected 1 2", done, steps_done);
      miscompares++;
    end
    idle_cycle();
  endtask

  initial begin
    vectors              = 0;
    miscompares          = 0;
    motor_rst            = 1'b1;
    step_pulse           = 1'b0;
    abort                = 1'b0;
    cif.cmd_valid        = 1'b0;
    cif.cmd_dir          = 1'b0;
    cif.cmd_steps        = '0;
    cif.cmd_start_period = '0;
    cif.cmd_min_period   = '0;
    cif.cmd_ramp_step    = '0;
    $display("[TB] motor_ramp_ctrl directed run");
    test_reset();
    test_trapezoid();
    test_triangle();
    test_zero_steps();
    test_abort();
    test_boundary();
    test_back_to_back();
    test_reset_midmove();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
